// File: rtl/rptr_empty_lvl.sv
// Read-side pointer and status block for an asynchronous FIFO: read binary/Gray
// pointers, registered empty/almost-empty flags, fill level, and sticky error flags.
module rptr_empty_lvl #(
    parameter int ADDRSIZE = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rinc,
    input  logic                rclr_err,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic                raempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                runderflow,
    output logic                rptr_err
);

    localparam logic [ADDRSIZE:0] DEPTH     = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] AE_THRESH = (ADDRSIZE+1)'(AE_LEVEL);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbin_next;
    logic [ADDRSIZE:0] rgray_next;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] lvl_next;
    logic              rd_en;
    logic              lvl_over;

    assign rd_en      = rinc & ~rempty;
    assign rbin_next  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
    assign rgray_next = (rbin_next >> 1) ^ rbin_next;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end
    end

    // Level is taken against the post-read pointer, so flags carry no extra latency.
    assign lvl_next = wbin - rbin_next;
    assign lvl_over = (lvl_next > DEPTH);
    assign raddr    = rbin[ADDRSIZE-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin       <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rlevel     <= '0;
            runderflow <= 1'b0;
            rptr_err   <= 1'b0;
        end else begin
            rbin    <= rbin_next;
            rptr    <= rgray_next;
            rempty  <= (rgray_next == rq2_wptr);
            raempty <= (lvl_next <= AE_THRESH);
            if (!lvl_over) begin
                rlevel <= lvl_next;
            end
            // Sticky flags: a set condition in the same cycle as a clear wins.
            runderflow <= (rinc & rempty) | (runderflow & ~rclr_err);
            rptr_err   <= lvl_over | (rptr_err & ~rclr_err);
        end
    end

endmodule

// File: tb/tb_rptr_empty_lvl.sv
// Self-checking bench for rptr_empty_lvl: directed scenarios plus randomized traffic
// checked against an arithmetic model of read count, write count and sticky flags.
module tb_rptr_empty_lvl;

    localparam int DEPTH = 16;
    localparam int MOD   = 32;
    localparam int AE    = 2;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       rinc = 1'b0;
    logic       rclr_err = 1'b0;
    logic [4:0] rq2_wptr = '0;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       raempty;
    logic [4:0] rlevel;
    logic       runderflow;
    logic       rptr_err;

    int errors = 0;
    int checks = 0;

    // Model: read count and write count as integers modulo 32.
    int m_r;
    int m_w;
    int m_level;
    bit m_empty;
    bit m_ae;
    bit m_uf;
    bit m_err;

    rptr_empty_lvl #(.ADDRSIZE(4), .AE_LEVEL(AE)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rinc       (rinc),
        .rclr_err   (rclr_err),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rlevel     (rlevel),
        .runderflow (runderflow),
        .rptr_err   (rptr_err)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] gray(input int v);
        logic [4:0] b;
        b = v[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_r     = 0;
        m_level = 0;
        m_empty = 1'b1;
        m_ae    = 1'b1;
        m_uf    = 1'b0;
        m_err   = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, return 1 unit later.
    task automatic tick(input bit rd, input bit clr, input int w);
        int lvl;
        int acc;
        rinc     = rd;
        rclr_err = clr;
        m_w      = ((w % MOD) + MOD) % MOD;
        rq2_wptr = gray(m_w);
        @(posedge rclk);
        acc     = (rd && !m_empty) ? 1 : 0;
        m_uf    = (rd && m_empty) || (m_uf && !clr);
        m_r     = (m_r + acc) % MOD;
        lvl     = (m_w - m_r + MOD) % MOD;
        m_empty = (lvl == 0);
        m_ae    = (lvl <= AE);
        if (lvl <= DEPTH) m_level = lvl;
        m_err   = (lvl > DEPTH) || (m_err && !clr);
        #1;
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge rclk);
        #1;
        checks++;
        if ({rempty, raempty, runderflow, rptr_err} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 1100", {rempty, raempty, runderflow, rptr_err});
        end
        checks++;
        if ({rlevel, raddr, rptr} !== 14'd0) begin
            errors++;
            $display("FAIL reset_values: rlevel=%0d raddr=%0d rptr=%b expected zeros", rlevel, raddr, rptr);
        end
        @(negedge rclk);
        rrst_n = 1'b1;
        tick(0, 0, 0);
        checks++;
        if ({rempty, raempty, rlevel, raddr} !== {1'b1, 1'b1, 5'd0, 4'd0}) begin
            errors++;
            $display("FAIL idle_after_reset: rempty=%b raempty=%b rlevel=%0d raddr=%0d", rempty, raempty, rlevel, raddr);
        end
    endtask

    task automatic test_write_visible();
        tick(0, 0, 5);
        checks++;
        if ({rempty, raempty, rlevel} !== {1'b0, 1'b0, 5'd5}) begin
            errors++;
            $display("FAIL write_visible: rempty=%b raempty=%b rlevel=%0d expected 0 0 5", rempty, raempty, rlevel);
        end
    endtask

    task automatic test_read_drain();
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 5);
            checks++;
            if (raddr !== 4'(i + 1) || rlevel !== 5'(4 - i) || raempty !== ((4 - i) <= AE)) begin
                errors++;
                $display("FAIL read_step%0d: raddr=%0d rlevel=%0d raempty=%b expected %0d %0d %b",
                         i, raddr, rlevel, raempty, i + 1, 4 - i, (4 - i) <= AE);
            end
        end
        repeat (2) tick(1, 0, 5);
        checks++;
        if ({rlevel, rempty, raempty, raddr} !== {5'd0, 1'b1, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL drain_empty: rlevel=%0d rempty=%b raempty=%b raddr=%0d expected 0 1 1 5", rlevel, rempty, raempty, raddr);
        end
    endtask

    task automatic test_underflow();
        repeat (2) tick(1, 0, 5);
        checks++;
        if (raddr !== 4'd5 || rptr !== gray(5) || runderflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set: raddr=%0d rptr=%b runderflow=%b expected 5 %b 1", raddr, rptr, runderflow, gray(5));
        end
        tick(1, 1, 5);
        checks++;
        if (runderflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set_wins: runderflow=%b expected 1", runderflow);
        end
        tick(0, 1, 5);
        checks++;
        if (runderflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: runderflow=%b expected 0", runderflow);
        end
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        while (m_r != 31 && guard < 80) begin
            tick(0, 0, m_r + 1);
            tick(1, 0, m_r + 1);
            guard++;
        end
        checks++;
        if (raddr !== 4'd15 || rempty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_preload: raddr=%0d rempty=%b expected 15 1", raddr, rempty);
        end
        tick(0, 0, 0);
        checks++;
        if (rempty !== 1'b0 || rlevel !== 5'd1) begin
            errors++;
            $display("FAIL wrap_level: rempty=%b rlevel=%0d expected 0 1", rempty, rlevel);
        end
        tick(1, 0, 0);
        checks++;
        if ({raddr, rptr, rempty, rptr_err} !== {4'd0, 5'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_read: raddr=%0d rptr=%b rempty=%b rptr_err=%b expected 0 00000 1 0", raddr, rptr, rempty, rptr_err);
        end
    endtask

    task automatic test_full();
        tick(0, 0, 16);
        checks++;
        if ({rlevel, rptr_err, rempty, raempty} !== {5'd16, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL full_level: rlevel=%0d rptr_err=%b rempty=%b raempty=%b expected 16 0 0 0", rlevel, rptr_err, rempty, raempty);
        end
    endtask

    task automatic test_ptr_err();
        tick(0, 0, 20);
        checks++;
        if (rptr_err !== 1'b1 || rlevel !== 5'd16) begin
            errors++;
            $display("FAIL ptr_err_set: rptr_err=%b rlevel=%0d expected 1 16", rptr_err, rlevel);
        end
        tick(0, 1, 20);
        checks++;
        if (rptr_err !== 1'b1) begin
            errors++;
            $display("FAIL ptr_err_set_wins: rptr_err=%b expected 1", rptr_err);
        end
        tick(0, 1, 4);
        checks++;
        if (rptr_err !== 1'b0 || rlevel !== 5'd4) begin
            errors++;
            $display("FAIL ptr_err_clear: rptr_err=%b rlevel=%0d expected 0 4", rptr_err, rlevel);
        end
    endtask

    task automatic test_simultaneous();
        tick(1, 0, 6);
        checks++;
        if (rlevel !== 5'd5 || raddr !== 4'd1) begin
            errors++;
            $display("FAIL simultaneous: rlevel=%0d raddr=%0d expected 5 1", rlevel, raddr);
        end
    endtask

    task automatic test_random();
        int w;
        int lvl;
        bit rd;
        bit clr;
        w = m_w;
        for (int n = 0; n < 600; n++) begin
            lvl = (w - m_r + MOD) % MOD;
            if (lvl < DEPTH && $urandom_range(0, 2) != 0) w = w + 1;
            rd  = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 63) == 0) begin
                tick(0, clr, m_r + 17 + $urandom_range(0, 9));
            end else begin
                tick(rd, clr, w);
            end
            checks++;
            if (raddr !== m_r[3:0] || rptr !== gray(m_r)) begin
                errors++;
                $display("FAIL rand_ptr[%0d]: raddr=%0d rptr=%b expected %0d %b", n, raddr, rptr, m_r % 16, gray(m_r));
            end
            checks++;
            if (rlevel !== m_level[4:0]) begin
                errors++;
                $display("FAIL rand_level[%0d]: rlevel=%0d expected %0d", n, rlevel, m_level);
            end
            checks++;
            if ({rempty, raempty, runderflow, rptr_err} !== {m_empty, m_ae, m_uf, m_err}) begin
                errors++;
                $display("FAIL rand_flags[%0d]: empty/ae/uf/err=%b expected %b", n,
                         {rempty, raempty, runderflow, rptr_err}, {m_empty, m_ae, m_uf, m_err});
            end
        end
    endtask

    task automatic test_async_reset();
        tick(0, 0, m_r + 3);
        tick(1, 0, m_r + 3);
        #2;
        rrst_n = 1'b0;
        #1;
        checks++;
        if ({rempty, raempty, runderflow, rptr_err, rlevel, raddr, rptr} !== {4'b1100, 14'd0}) begin
            errors++;
            $display("FAIL async_reset: empty/ae/uf/err=%b rlevel=%0d raddr=%0d rptr=%b expected 1100 0 0 00000",
                     {rempty, raempty, runderflow, rptr_err}, rlevel, raddr, rptr);
        end
        model_reset();
        @(negedge rclk);
        rrst_n = 1'b1;
        tick(0, 0, 0);
        checks++;
        if (rempty !== 1'b1 || rlevel !== 5'd0) begin
            errors++;
            $display("FAIL after_async_reset: rempty=%b rlevel=%0d expected 1 0", rempty, rlevel);
        end
    endtask

    initial begin
        test_reset();
        test_write_visible();
        test_read_drain();
        test_underflow();
        test_wrap();
        test_full();
        test_ptr_err();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
